// File: rtl/ramfill.sv
// ramfill: single-shot ADC capture buffer with a registered VGA read port.
// Optional trigger arming is compiled in with `define RAMFILL_TRIGGER_EN.
module ramfill #(
   parameter int              DW         = 8,
   parameter int              AW         = 8,
   parameter logic [DW-1:0]   TRIG_LEVEL = 8'h80
) (
   input  logic          clk_adc,
   input  logic          reset,
   input  logic          enable,
   input  logic [DW-1:0] adc_data,
   input  logic [AW-1:0] vga_x,
   output logic [DW-1:0] vga_data,
   output logic [AW-1:0] CounterX,
   output logic          finished
);

   localparam int            DEPTH = 2**AW;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH-1);

`ifdef RAMFILL_TRIGGER_EN
   typedef enum logic [1:0] {IDLE, ARM, FILL, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
`endif

   state_t        state;
   state_t        state_nx;
   logic [DW-1:0] mem [DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] cnt_nx;
   logic          fin_nx;

`ifdef RAMFILL_TRIGGER_EN
   logic [DW-1:0] prev;
   logic          crossing;

   assign crossing = (prev < TRIG_LEVEL) && (adc_data >= TRIG_LEVEL);

   // Previous sample for edge detection; tracks the ADC in every state.
   always_ff @(posedge clk_adc or negedge reset) begin
      if (!reset) prev <= '0;
      else        prev <= adc_data;
   end
`endif

   always_ff @(posedge clk_adc or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_addr  = CounterX;
      wr_data  = adc_data;
      cnt_nx   = CounterX;
      fin_nx   = finished;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
`ifdef RAMFILL_TRIGGER_EN
            if (enable) state_nx = ARM;
`else
            if (enable) state_nx = FILL;
`endif
         end
`ifdef RAMFILL_TRIGGER_EN
         ARM: begin
            if (!enable) begin
               state_nx = IDLE;
            end else if (crossing) begin
               // Crossing sample lands at address 0 as the fill begins.
               wr_en    = 1'b1;
               wr_addr  = '0;
               cnt_nx   = AW'(1);
               state_nx = FILL;
            end
         end
`endif
         FILL: begin
            if (enable) begin
               wr_en = 1'b1;
               if (CounterX == LAST) begin
                  fin_nx   = 1'b1;
                  state_nx = DONE;
               end else begin
                  cnt_nx = CounterX + AW'(1);
               end
            end
         end
         DONE: begin
            cnt_nx = LAST;
            fin_nx = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_adc or negedge reset) begin
      if (!reset) begin
         CounterX <= '0;
         finished <= 1'b0;
      end else begin
         CounterX <= cnt_nx;
         finished <= fin_nx;
      end
   end

   // Storage is never cleared, so it stays out of the reset domain.
   always_ff @(posedge clk_adc) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read-first: a same-address write this edge is not yet visible.
   always_ff @(posedge clk_adc or negedge reset) begin
      if (!reset) vga_data <= '0;
      else        vga_data <= mem[vga_x];
   end

endmodule

// File: tb/tb_ramfill.sv
// tb_ramfill: random and directed stimulus for ramfill against a
// sample-level model of the capture buffer and its read port.
module tb_ramfill;

   logic       clk_adc  = 1'b0;
   logic       reset    = 1'b1;
   logic       enable   = 1'b0;
   logic [7:0] adc_data = '0;
   logic [7:0] vga_x    = '0;
   logic [7:0] vga_data;
   logic [7:0] CounterX;
   logic       finished;

   int tests = 0;
   int fails = 0;

   always #5 clk_adc = ~clk_adc;

   ramfill dut (
      .clk_adc  (clk_adc),
      .reset    (reset),
      .enable   (enable),
      .adc_data (adc_data),
      .vga_x    (vga_x),
      .vga_data (vga_data),
      .CounterX (CounterX),
      .finished (finished)
   );

   // Model: what has been captured so far, and where the next sample goes.
   logic [7:0] m_mem [256];
   bit         m_ok  [256];
   int         m_cnt    = 0;
   bit         m_fill   = 0;
   bit         m_done   = 0;
   logic [7:0] m_vga    = '0;
   bit         m_vga_ok = 1;
   bit         chk_on   = 0;

   always @(posedge clk_adc or negedge reset) begin
      if (!reset) begin
         m_cnt    = 0;
         m_fill   = 0;
         m_done   = 0;
         m_vga    = '0;
         m_vga_ok = 1;
      end else begin
         m_vga    = m_mem[vga_x];
         m_vga_ok = m_ok[vga_x];
         if (!m_done) begin
            if (!m_fill) begin
               if (enable) m_fill = 1;
            end else if (enable) begin
               m_mem[m_cnt] = adc_data;
               m_ok[m_cnt]  = 1;
               if (m_cnt == 255) m_done = 1;
               else              m_cnt++;
            end
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic timeout(string name);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   always @(negedge clk_adc) begin
      if (chk_on) begin
         check("cycle_cnt", CounterX, m_cnt);
         check("cycle_fin", finished, m_done);
         if (m_vga_ok) check("cycle_vga", vga_data, m_vga);
      end
   end

   task automatic tick;
      @(negedge clk_adc);
      #1;
   endtask

   task automatic rand_vga;
      if ($urandom_range(3) == 0) vga_x = 8'(m_cnt);
      else                        vga_x = 8'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int held;

      #1 reset = 1'b0;
      chk_on = 1;
      repeat (2) @(negedge clk_adc);
      check("rst_cnt", CounterX, 0);
      check("rst_fin", finished, 0);
      check("rst_vga", vga_data, 0);
      #1;

      // Ramp fill: sample value equals its address.
      reset  = 1'b1;
      enable = 1'b1;
      for (int e = 0; e <= 256; e++) begin
         adc_data = (e == 0) ? 8'($urandom) : 8'(e - 1);
         rand_vga();
         tick();
         if (e == 0)   check("entry_cnt", CounterX, 0);
         if (e == 1)   check("first_cnt", CounterX, 1);
         if (e == 255) check("fin_early", finished, 0);
         if (e == 256) begin
            check("fin_time", finished, 1);
            check("cnt_last", CounterX, 255);
         end
      end

      // Done: enable toggles and new data must not disturb the ramp.
      for (int i = 0; i < 256; i++) begin
         vga_x    = 8'(i);
         enable   = 1'($urandom);
         adc_data = 8'($urandom);
         tick();
         check("readback", vga_data, i);
      end
      check("done_cnt", CounterX, 255);
      check("done_fin", finished, 1);

      // Random fill with a long pause.
      reset = 1'b0;
      tick();
      tick();
      reset  = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 80; i++) begin
         adc_data = 8'($urandom);
         rand_vga();
         tick();
      end
      held   = m_cnt;
      enable = 1'b0;
      for (int i = 0; i < 50; i++) begin
         adc_data = 8'($urandom);
         rand_vga();
         tick();
      end
      check("pause_hold", CounterX, held);
      n = 0;
      while (!m_done && n < 1000) begin
         enable   = ($urandom_range(3) != 0);
         adc_data = 8'($urandom);
         rand_vga();
         tick();
         n++;
      end
      if (!m_done) timeout("rand_fill");
      check("rand_fin", finished, 1);
      for (int i = 0; i < 64; i++) begin
         vga_x    = 8'($urandom);
         enable   = 1'($urandom);
         adc_data = 8'($urandom);
         tick();
      end

      // Abort a fill at address 100 with an async reset.
      reset = 1'b0;
      tick();
      reset  = 1'b1;
      enable = 1'b1;
      n = 0;
      while (m_cnt != 100 && n < 300) begin
         adc_data = 8'($urandom);
         rand_vga();
         tick();
         n++;
      end
      if (m_cnt != 100) timeout("reach_100");
      check("pre_abort", CounterX, 100);
      enable = 1'b0;
      @(posedge clk_adc);
      #2 reset = 1'b0;
      #1;
      check("async_cnt", CounterX, 0);
      check("async_fin", finished, 0);
      tick();
      reset  = 1'b1;
      enable = 1'b1;
      n = 0;
      while (!m_done && n < 400) begin
         adc_data = 8'($urandom);
         rand_vga();
         tick();
         n++;
      end
      if (!m_done) timeout("refill");
      check("refill_fin", finished, 1);
      check("refill_cnt", CounterX, 255);
      for (int i = 0; i < 64; i++) begin
         vga_x    = 8'($urandom);
         enable   = 1'($urandom);
         adc_data = 8'($urandom);
         tick();
      end

      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
